// File: rtl/small_multiplier_pkg.sv
// Constants shared by the small arithmetic blocks: FSM state encoding and a
// constant clog2 used to size iteration counters.
package small_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2, usable in constant expressions for parameter-derived widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = 32'(i + 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/small_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock,
// fixed latency, start/busy/done handshake.
module small_multiplier
  import small_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     c,
  output logic                 overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic             ready_c;
  logic             accept_c;
  logic             run_c;
  logic             last_c;
  logic             busy_next_c;
  logic             done_next_c;
  logic [PW-1:0]    acc_next_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (count == CW'(WIDTH - 1)) next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake decode and the partial-product add for the current bit
  always_comb begin
    ready_c     = (state == ST_IDLE) || (state == ST_DONE);
    accept_c    = ready_c && start;
    run_c       = (state == ST_RUN);
    last_c      = run_c && (count == CW'(WIDTH - 1));
    busy_next_c = (next_state == ST_RUN);
    done_next_c = (next_state == ST_DONE);
    acc_next_c  = acc;
    if (mplier[0]) acc_next_c = acc + (PW'(mcand) << count);
  end

  // Datapath and registered outputs; results only update on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      c        <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
    end else begin
      busy <= busy_next_c;
      done <= done_next_c;
      if (accept_c) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end else if (run_c) begin
        acc    <= acc_next_c;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (last_c) begin
          product  <= acc_next_c;
          c        <= acc_next_c[WIDTH-1:0];
          overflow <= |acc_next_c[PW-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_small_multiplier.sv
// Directed bench for small_multiplier (WIDTH=8): latency, results, back-to-back
// accept, ignored start while busy, and reset behaviour.
module tb_small_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  c;
  logic        overflow;

  int pass_cnt;
  int total_cnt;
  int busy_cnt;
  int done_at;
  int extra_done;

  small_multiplier #(.WIDTH(8)) dut (
    .clock    (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .c        (c),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present operands with start for one edge; operands are scrambled afterwards.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hAA;
    b = 8'h55;
  endtask

  // Called at negedge number 'first' after the accepting edge; returns the
  // negedge index where done was seen (0 if never) and busy cycles counted.
  task automatic wait_done(input int first, output int bcnt, output int dat);
    bcnt = first - 1;
    dat  = 0;
    for (int i = first; i <= 30; i++) begin
      if (done) begin
        dat = i;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_product", 32'(product), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    // 8*4
    issue(8'd8, 8'd4);
    wait_done(1, busy_cnt, done_at);
    check("t1_busy_cycles", 32'(busy_cnt), 8);
    check("t1_done_at", 32'(done_at), 9);
    check("t1_product", 32'(product), 32);
    check("t1_c", 32'(c), 32);
    check("t1_ovf", 32'(overflow), 0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 0);
    check("t1_hold", 32'(product), 32);

    // 123*5 = 615
    issue(8'd123, 8'd5);
    check("t2_hold_busy", 32'(product), 32);
    wait_done(1, busy_cnt, done_at);
    check("t2_done_at", 32'(done_at), 9);
    check("t2_product", 32'(product), 615);
    check("t2_c", 32'(c), 103);
    check("t2_ovf", 32'(overflow), 1);
    @(negedge clk);

    // 255*255 then back-to-back 1*5 accepted in the done cycle
    issue(8'd255, 8'd255);
    wait_done(1, busy_cnt, done_at);
    check("t3_done_at", 32'(done_at), 9);
    check("t3_product", 32'(product), 65025);
    check("t3_c", 32'(c), 1);
    check("t3_ovf", 32'(overflow), 1);
    issue(8'd1, 8'd5);
    check("t3b_busy", 32'(busy), 1);
    check("t3b_done_low", 32'(done), 0);
    check("t3b_hold", 32'(product), 65025);
    wait_done(1, busy_cnt, done_at);
    check("t3b_done_at", 32'(done_at), 9);
    check("t3b_product", 32'(product), 5);
    check("t3b_ovf", 32'(overflow), 0);
    @(negedge clk);

    // 0*10: no early termination
    issue(8'd0, 8'd10);
    wait_done(1, busy_cnt, done_at);
    check("t4_busy_cycles", 32'(busy_cnt), 8);
    check("t4_done_at", 32'(done_at), 9);
    check("t4_product", 32'(product), 0);
    check("t4_ovf", 32'(overflow), 0);
    @(negedge clk);

    // 3*7 with an ignored start on busy cycle 3
    issue(8'd3, 8'd7);
    @(negedge clk);
    @(negedge clk);
    check("t5_busy3", 32'(busy), 1);
    issue(8'd200, 8'd200);
    wait_done(4, busy_cnt, done_at);
    check("t5_done_at", 32'(done_at), 9);
    check("t5_product", 32'(product), 21);
    @(negedge clk);
    count_done(15, extra_done);
    check("t5_no_second_done", 32'(extra_done), 0);

    // 15*15 interrupted by reset on busy cycle 4
    issue(8'd15, 8'd15);
    repeat (3) @(negedge clk);
    check("t6_busy4", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_product", 32'(product), 0);
    check("t6_c", 32'(c), 0);
    count_done(15, extra_done);
    check("t6_no_done", 32'(extra_done), 0);

    // reset and start together: start is dropped
    reset = 1'b1;
    issue(8'd9, 8'd9);
    reset = 1'b0;
    check("t7_busy", 32'(busy), 0);
    count_done(12, extra_done);
    check("t7_no_done", 32'(extra_done), 0);

    // fresh 2*3 after reset
    issue(8'd2, 8'd3);
    wait_done(1, busy_cnt, done_at);
    check("t8_done_at", 32'(done_at), 9);
    check("t8_product", 32'(product), 6);
    check("t8_ovf", 32'(overflow), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
